n101_icb32towishb8_seq: RTL and testbench
=========================================

N101_ICB32TOWISHB8_SEQ -- requirements
Module: n101_icb32towishb8_seq

Interface
Parameters:
REQ-001 SHALL provide parameter AW, default 32, address width.
REQ-002 SHALL provide parameter TMO_W, default 8, timeout counter width; timeout limit = 2^TMO_W-1 cycles.

Ports:
REQ-003 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- i_icb_cmd_valid  in  1  command request
- i_icb_cmd_ready  out  1  command accept
- i_icb_cmd_read  in  1  1=read, 0=write
- i_icb_cmd_addr  in  AW  byte address
- i_icb_cmd_wdata  in  32  write data, lane-aligned
- i_icb_cmd_wmask  in  4  write byte enables
- i_icb_cmd_size  in  2  0=byte, 1=half, 2=word, 3=illegal
- i_icb_rsp_valid  out  1  response valid
- i_icb_rsp_ready  in  1  response accept
- i_icb_rsp_err  out  1  response error
- i_icb_rsp_rdata  out  32  read data, lane-aligned
- wb_adr  out  AW  Wishbone byte address
- wb_dat_w  out  8  Wishbone write byte
- wb_dat_r  in  8  Wishbone read byte
- wb_we  out  1  Wishbone write enable
- wb_stb  out  1  Wishbone strobe
- wb_cyc  out  1  Wishbone cycle
- wb_ack  in  1  Wishbone acknowledge

Function
REQ-004 SHALL implement FSM states IDLE, BUS, RSP; all Wishbone and ICB response outputs registered.
REQ-005 i_icb_cmd_ready SHALL be 1 only in IDLE; cmd handshake latches read, addr, wdata, wmask, size.
REQ-006 Beat count SHALL be 1<<size; start lane = addr[1:0] with low size bits cleared (misaligned addresses are aligned down, no error).
REQ-007 Beat k SHALL drive wb_adr = {addr[AW-1:2], start_lane+k}, wb_we = ~read, wb_dat_w = wdata byte of that lane.
REQ-008 On writes, beats whose wmask bit is 0 SHALL be skipped (no bus cycle); a write with no enabled lane in range SHALL go directly IDLE->RSP with err=0.
REQ-009 size=3 SHALL go directly IDLE->RSP with err=1 and no bus cycle.
REQ-010 In BUS, wb_cyc and wb_stb SHALL be 1; both SHALL stay 1 across consecutive beats, with address/data updated the cycle after wb_ack.
REQ-011 On wb_ack of a read beat, wb_dat_r SHALL be stored into rdata[lane*8+:8]; lanes not read SHALL be 0.
REQ-012 After the ack of the last beat, the FSM SHALL go to RSP with wb_cyc=wb_stb=0 the next cycle.
REQ-013 Latency: a single-beat access with wb_ack on the first stb cycle SHALL give rsp_valid 2 cycles after the cmd handshake.
REQ-014 The timeout counter SHALL clear on each beat start and on wb_ack, and increment each BUS cycle without ack.
REQ-015 On timeout the block SHALL drop cyc/stb, abort remaining beats, and go to RSP with err=1; rdata keeps the lanes already captured.
REQ-016 wb_ack outside BUS SHALL be ignored.
REQ-017 In RSP, rsp_valid, rsp_err and rsp_rdata SHALL be held stable until rsp_ready; the handshake returns the FSM to IDLE.
REQ-018 A new command SHALL NOT be accepted in the same cycle as the response handshake (cmd_ready rises the cycle after).

Reset
REQ-019 Reset SHALL force state IDLE, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, wb_cyc=wb_stb=wb_we=0, wb_adr=0, wb_dat_w=0, and counters 0.
REQ-020 Reset asserted mid-BUS SHALL drop wb_cyc/wb_stb immediately and discard the transaction; no response is issued.

Structure
REQ-021 The FSM state encoding, size encodings and beat-count function SHALL live in the shared package n101_defines.
REQ-022 The timeout counter SHALL be a sub-module n101_wb_tmo_cnt (inputs clr, inc; output expired).

Verification
REQ-023 Word read addr 0x100, wb_ack on each first stb cycle, bytes 0x11,0x22,0x33,0x44 -> wb_adr 0x100..0x103, rdata 0x44332211, err=0.
REQ-024 Half write addr 0x202, wdata 0xAABB0000, wmask 0b1100 -> two writes: 0x202=0xBB, 0x203=0xAA; rsp err=0.
REQ-025 Word write wmask 0b0101 -> exactly two bus cycles at lanes 0 and 2; wmask 0b0000 -> no bus cycle, immediate err=0 response.
REQ-026 Byte read with wb_ack never asserted -> cyc drops after 255 cycles, rsp err=1, rdata 0.
REQ-027 size=3 -> no bus cycle, err=1; rsp_ready held low 5 cycles -> outputs stable throughout.
REQ-028 rst asserted during beat 2 of a word read -> cyc=0 at once, no rsp_valid; the next command completes normally.

Source files
------------

// File: rtl/n101_defines.sv
// Shared definitions for the 32-bit ICB to 8-bit Wishbone sequencer:
// FSM states, access size codes and lane/beat helpers.
package n101_defines;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    function automatic logic [2:0] beat_cnt(input logic [1:0] size);
        return 3'd1 << size;
    endfunction

    // Byte lanes covered by an access; the start lane is aligned down to the size.
    // The illegal size yields an empty span.
    function automatic logic [3:0] lane_span(input logic [1:0] lo, input logic [1:0] size);
        logic [2:0] n;
        logic [1:0] start;
        logic [4:0] ones;
        n     = beat_cnt(size);
        start = lo & ~2'(n - 3'd1);
        ones  = (5'd1 << n) - 5'd1;
        return ones[3:0] << start;
    endfunction

    function automatic logic [1:0] first_lane(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

endpackage

// File: rtl/n101_wb_tmo_cnt.sv
// Wishbone beat watchdog: counts unacknowledged bus cycles of the current beat.
// expired flags the cycle that is the (2^TMO_W-1)-th without an ack.
module n101_wb_tmo_cnt #(
    parameter int TMO_W = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [TMO_W-1:0] LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    logic [TMO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc)
            cnt_d = cnt_q + TMO_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/n101_icb32towishb8_seq.sv
// Bridges one 32-bit ICB command into a sequence of 8-bit Wishbone beats,
// one per enabled byte lane, then returns a single ICB response.
module n101_icb32towishb8_seq #(
    parameter int AW    = 32,
    parameter int TMO_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_icb_cmd_valid,
    output logic          i_icb_cmd_ready,
    input  logic          i_icb_cmd_read,
    input  logic [AW-1:0] i_icb_cmd_addr,
    input  logic [31:0]   i_icb_cmd_wdata,
    input  logic [3:0]    i_icb_cmd_wmask,
    input  logic [1:0]    i_icb_cmd_size,
    output logic          i_icb_rsp_valid,
    input  logic          i_icb_rsp_ready,
    output logic          i_icb_rsp_err,
    output logic [31:0]   i_icb_rsp_rdata,
    output logic [AW-1:0] wb_adr,
    output logic [7:0]    wb_dat_w,
    input  logic [7:0]    wb_dat_r,
    output logic          wb_we,
    output logic          wb_stb,
    output logic          wb_cyc,
    input  logic          wb_ack
);
    import n101_defines::*;

    state_e        state_q, state_d;
    logic          read_q, read_d;
    logic [AW-3:0] addr_hi_q, addr_hi_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    pend_q, pend_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [7:0]    datw_q, datw_d;

    logic       tmo_clr, tmo_inc, tmo_exp;
    logic [3:0] span, en_lanes, rem;
    logic [1:0] cur_lane, nxt_lane;

    assign tmo_clr = (state_q != ST_BUS) | wb_ack;
    assign tmo_inc = (state_q == ST_BUS) & ~wb_ack;

    n101_wb_tmo_cnt #(.TMO_W(TMO_W)) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmo_clr),
        .inc     (tmo_inc),
        .expired (tmo_exp)
    );

    always_comb begin
        state_d     = state_q;
        read_d      = read_q;
        addr_hi_d   = addr_hi_q;
        wdata_d     = wdata_q;
        pend_d      = pend_q;
        rdata_d     = rdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        datw_d      = datw_q;
        span        = lane_span(i_icb_cmd_addr[1:0], i_icb_cmd_size);
        en_lanes    = i_icb_cmd_read ? span : (span & i_icb_cmd_wmask);
        cur_lane    = adr_q[1:0];
        rem         = pend_q & ~(4'b0001 << cur_lane);
        nxt_lane    = 2'd0;

        case (state_q)
            ST_IDLE: begin
                if (i_icb_cmd_valid) begin
                    read_d    = i_icb_cmd_read;
                    addr_hi_d = i_icb_cmd_addr[AW-1:2];
                    wdata_d   = i_icb_cmd_wdata;
                    rdata_d   = '0;
                    if (i_icb_cmd_size == SZ_ILL) begin
                        state_d     = ST_RSP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (en_lanes == 4'b0000) begin
                        state_d     = ST_RSP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                    end else begin
                        nxt_lane = first_lane(en_lanes);
                        state_d  = ST_BUS;
                        pend_d   = en_lanes;
                        cyc_d    = 1'b1;
                        we_d     = ~i_icb_cmd_read;
                        adr_d    = {i_icb_cmd_addr[AW-1:2], nxt_lane};
                        datw_d   = i_icb_cmd_wdata[{nxt_lane, 3'b000} +: 8];
                    end
                end
            end
            ST_BUS: begin
                if (wb_ack) begin
                    if (read_q)
                        rdata_d[{cur_lane, 3'b000} +: 8] = wb_dat_r;
                    pend_d = rem;
                    if (rem == 4'b0000) begin
                        state_d     = ST_RSP;
                        cyc_d       = 1'b0;
                        we_d        = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                    end else begin
                        // Strobe stays high; the next enabled lane starts right away.
                        nxt_lane = first_lane(rem);
                        adr_d    = {addr_hi_q, nxt_lane};
                        datw_d   = wdata_q[{nxt_lane, 3'b000} +: 8];
                    end
                end else if (tmo_exp) begin
                    state_d     = ST_RSP;
                    cyc_d       = 1'b0;
                    we_d        = 1'b0;
                    pend_d      = 4'b0000;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            ST_RSP: begin
                if (i_icb_rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            read_q      <= 1'b0;
            addr_hi_q   <= '0;
            wdata_q     <= '0;
            pend_q      <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            datw_q      <= '0;
        end else begin
            state_q     <= state_d;
            read_q      <= read_d;
            addr_hi_q   <= addr_hi_d;
            wdata_q     <= wdata_d;
            pend_q      <= pend_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            datw_q      <= datw_d;
        end
    end

    assign i_icb_cmd_ready = (state_q == ST_IDLE);
    assign i_icb_rsp_valid = rsp_valid_q;
    assign i_icb_rsp_err   = rsp_err_q;
    assign i_icb_rsp_rdata = rdata_q;
    assign wb_adr          = adr_q;
    assign wb_dat_w        = datw_q;
    assign wb_we           = we_q;
    assign wb_stb          = cyc_q;
    assign wb_cyc          = cyc_q;

endmodule

// File: tb/tb_n101_icb32towishb8_seq.sv
// Bench for the ICB-to-Wishbone byte sequencer: a lane-level reference model
// predicts bus beats and responses; a Wishbone slave with programmable ack delay.
module tb_n101_icb32towishb8_seq;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_icb_cmd_valid = 1'b0;
    logic          i_icb_cmd_ready;
    logic          i_icb_cmd_read = 1'b0;
    logic [AW-1:0] i_icb_cmd_addr = '0;
    logic [31:0]   i_icb_cmd_wdata = '0;
    logic [3:0]    i_icb_cmd_wmask = '0;
    logic [1:0]    i_icb_cmd_size = '0;
    logic          i_icb_rsp_valid;
    logic          i_icb_rsp_ready = 1'b0;
    logic          i_icb_rsp_err;
    logic [31:0]   i_icb_rsp_rdata;
    logic [AW-1:0] wb_adr;
    logic [7:0]    wb_dat_w;
    logic [7:0]    wb_dat_r;
    logic          wb_we, wb_stb, wb_cyc;
    logic          wb_ack;

    always #5 clk = ~clk;

    n101_icb32towishb8_seq #(.AW(AW), .TMO_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_icb_cmd_valid (i_icb_cmd_valid),
        .i_icb_cmd_ready (i_icb_cmd_ready),
        .i_icb_cmd_read  (i_icb_cmd_read),
        .i_icb_cmd_addr  (i_icb_cmd_addr),
        .i_icb_cmd_wdata (i_icb_cmd_wdata),
        .i_icb_cmd_wmask (i_icb_cmd_wmask),
        .i_icb_cmd_size  (i_icb_cmd_size),
        .i_icb_rsp_valid (i_icb_rsp_valid),
        .i_icb_rsp_ready (i_icb_rsp_ready),
        .i_icb_rsp_err   (i_icb_rsp_err),
        .i_icb_rsp_rdata (i_icb_rsp_rdata),
        .wb_adr          (wb_adr),
        .wb_dat_w        (wb_dat_w),
        .wb_dat_r        (wb_dat_r),
        .wb_we           (wb_we),
        .wb_stb          (wb_stb),
        .wb_cyc          (wb_cyc),
        .wb_ack          (wb_ack)
    );

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [7:0]  dat;
    } beat_t;

    int          tests = 0;
    int          fails = 0;
    beat_t       exp_q[$];
    beat_t       log_q[$];
    int          n_acked = 0;
    int          n_cyc = 0;
    int          ack_delay = 0;
    bit          ack_never = 1'b0;
    bit          spurious = 1'b0;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_nbeats;
    logic        obs_err;
    logic [31:0] obs_rdata;
    int          lat;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endfunction

    // Slave memory contents: 0x100..0x103 read back 0x11,0x22,0x33,0x44.
    function automatic logic [7:0] rbyte(input logic [31:0] a);
        logic [7:0] lo;
        lo = {6'd0, a[1:0]} + 8'd1;
        return 8'(lo * 8'h11) ^ a[15:8] ^ 8'h01;
    endfunction

    // Reference: which lanes become bus beats and what the response must be.
    task automatic model(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] wm, input logic [1:0] sz);
        int    n, lo, start;
        beat_t b;
        exp_q.delete();
        exp_rdata  = '0;
        exp_nbeats = 0;
        exp_err    = 1'b0;
        if (sz == 2'd3) begin
            exp_err = 1'b1;
            return;
        end
        n     = 1 << sz;
        lo    = int'(a[1:0]);
        start = (lo / n) * n;
        for (int k = 0; k < n; k++) begin
            int ln;
            ln = start + k;
            if (rd || wm[ln]) begin
                b.adr = {a[31:2], 2'(ln)};
                b.we  = !rd;
                b.dat = rd ? 8'h00 : wd[ln*8 +: 8];
                exp_q.push_back(b);
                exp_nbeats++;
                if (rd) exp_rdata[ln*8 +: 8] = rbyte(b.adr);
            end
        end
        if (ack_never && exp_nbeats > 0) begin
            exp_err    = 1'b1;
            exp_rdata  = '0;
            exp_nbeats = 0;
        end
    endtask

    // Wishbone slave: ack after ack_delay wait cycles per beat.
    initial begin
        int wcnt;
        wcnt = 0;
        wb_ack = 1'b0;
        wb_dat_r = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (!(wb_cyc && wb_stb)) begin
                wb_ack = spurious;
                wcnt = 0;
            end else begin
                if (wb_ack) wcnt = 0;
                if (!ack_never && wcnt == ack_delay) begin
                    wb_ack   = 1'b1;
                    wb_dat_r = rbyte(wb_adr);
                end else begin
                    wb_ack = 1'b0;
                end
                wcnt++;
            end
        end
    end

    // Per-cycle bus check against the predicted beat list.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("stb_eq_cyc", 64'(wb_stb), 64'(wb_cyc));
                if (wb_cyc) begin
                    n_cyc++;
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL beat_unexpected: adr 0x%0h, no beat predicted", wb_adr);
                    end else begin
                        chk("beat_adr", 64'(wb_adr), 64'(exp_q[0].adr));
                        chk("beat_we", 64'(wb_we), 64'(exp_q[0].we));
                        if (exp_q[0].we) chk("beat_dat", 64'(wb_dat_w), 64'(exp_q[0].dat));
                        if (wb_ack) begin
                            b.adr = wb_adr;
                            b.we  = wb_we;
                            b.dat = wb_dat_w;
                            log_q.push_back(b);
                            void'(exp_q.pop_front());
                            n_acked++;
                        end
                    end
                end
            end
        end
    end

    task automatic send_cmd(input logic rd, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] wm, input logic [1:0] sz, output bit ok);
        ok = 1'b0;
        @(posedge clk);
        #1;
        i_icb_cmd_valid = 1'b1;
        i_icb_cmd_read  = rd;
        i_icb_cmd_addr  = a;
        i_icb_cmd_wdata = wd;
        i_icb_cmd_wmask = wm;
        i_icb_cmd_size  = sz;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i_icb_cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            tests++;
            fails++;
            $display("FAIL cmd_accept: cmd_ready never seen, want 1");
        end
        i_icb_cmd_valid = 1'b0;
    endtask

    task automatic do_cmd(input string nm, input logic rd, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] wm, input logic [1:0] sz,
                          input int hold, output int latency);
        bit ok;
        latency = 0;
        model(rd, a, wd, wm, sz);
        n_acked = 0;
        n_cyc   = 0;
        log_q.delete();
        send_cmd(rd, a, wd, wm, sz, ok);
        if (!ok) return;
        ok = 1'b0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (i_icb_rsp_valid) begin
                latency = i;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL %s_rsp: rsp_valid never seen, want 1", nm);
            return;
        end
        obs_err   = i_icb_rsp_err;
        obs_rdata = i_icb_rsp_rdata;
        chk({nm, "_err"}, 64'(i_icb_rsp_err), 64'(exp_err));
        chk({nm, "_rdata"}, 64'(i_icb_rsp_rdata), 64'(exp_rdata));
        chk({nm, "_nbeats"}, 64'(n_acked), 64'(exp_nbeats));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({nm, "_hold_valid"}, 64'(i_icb_rsp_valid), 64'(1));
            chk({nm, "_hold_err"}, 64'(i_icb_rsp_err), 64'(exp_err));
            chk({nm, "_hold_rdata"}, 64'(i_icb_rsp_rdata), 64'(exp_rdata));
            chk({nm, "_hold_cyc"}, 64'(wb_cyc), 64'(0));
        end
        i_icb_rsp_ready = 1'b1;
        chk({nm, "_no_accept_in_rsp"}, 64'(i_icb_cmd_ready), 64'(0));
        @(posedge clk);
        #1;
        i_icb_rsp_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_ready_after"}, 64'(i_icb_cmd_ready), 64'(1));
        chk({nm, "_valid_drop"}, 64'(i_icb_rsp_valid), 64'(0));
        if (!ack_never) chk({nm, "_beats_left"}, 64'(exp_q.size()), 64'(0));
        else exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        // Reset state
        @(negedge clk);
        chk("rst_cmd_ready", 64'(i_icb_cmd_ready), 64'(1));
        chk("rst_rsp_valid", 64'(i_icb_rsp_valid), 64'(0));
        chk("rst_rsp_err", 64'(i_icb_rsp_err), 64'(0));
        chk("rst_rsp_rdata", 64'(i_icb_rsp_rdata), 64'(0));
        chk("rst_cyc", 64'(wb_cyc), 64'(0));
        chk("rst_stb", 64'(wb_stb), 64'(0));
        chk("rst_we", 64'(wb_we), 64'(0));
        chk("rst_adr", 64'(wb_adr), 64'(0));
        chk("rst_dat_w", 64'(wb_dat_w), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        ack_delay = 0;
        do_cmd("word_rd", 1'b1, 32'h100, 32'h0, 4'h0, 2'd2, 0, lat);
        chk("word_rd_lit", 64'(obs_rdata), 64'h44332211);
        chk("word_rd_lit_err", 64'(obs_err), 64'(0));
        chk("word_rd_cyc_cycles", 64'(n_cyc), 64'(4));
        chk("word_rd_adr0", 64'(log_q[0].adr), 64'h100);
        chk("word_rd_adr3", 64'(log_q[3].adr), 64'h103);

        do_cmd("byte_rd", 1'b1, 32'h101, 32'h0, 4'h0, 2'd0, 0, lat);
        chk("byte_rd_latency", 64'(lat), 64'(2));
        chk("byte_rd_lit", 64'(obs_rdata), 64'h0000_2200);

        do_cmd("half_wr", 1'b0, 32'h202, 32'hAABB_0000, 4'b1100, 2'd1, 0, lat);
        chk("half_wr_n", 64'(n_acked), 64'(2));
        chk("half_wr_adr0", 64'(log_q[0].adr), 64'h202);
        chk("half_wr_dat0", 64'(log_q[0].dat), 64'hBB);
        chk("half_wr_adr1", 64'(log_q[1].adr), 64'h203);
        chk("half_wr_dat1", 64'(log_q[1].dat), 64'hAA);

        ack_delay = 1;
        do_cmd("word_wr_skip", 1'b0, 32'h300, 32'h1234_5678, 4'b0101, 2'd2, 0, lat);
        chk("skip_n", 64'(n_acked), 64'(2));
        chk("skip_adr0", 64'(log_q[0].adr), 64'h300);
        chk("skip_dat0", 64'(log_q[0].dat), 64'h78);
        chk("skip_adr1", 64'(log_q[1].adr), 64'h302);
        chk("skip_dat1", 64'(log_q[1].dat), 64'h34);

        do_cmd("word_wr_nomask", 1'b0, 32'h300, 32'h1234_5678, 4'b0000, 2'd2, 0, lat);
        chk("nomask_latency", 64'(lat), 64'(1));
        chk("nomask_cyc_cycles", 64'(n_cyc), 64'(0));
        chk("nomask_err", 64'(obs_err), 64'(0));

        do_cmd("half_wr_outrange", 1'b0, 32'h200, 32'hFFFF_FFFF, 4'b1100, 2'd1, 0, lat);
        chk("outrange_cyc_cycles", 64'(n_cyc), 64'(0));

        ack_delay = 2;
        do_cmd("half_rd_mis", 1'b1, 32'h103, 32'h0, 4'h0, 2'd1, 0, lat);
        chk("mis_lit", 64'(obs_rdata), 64'h4433_0000);
        chk("mis_adr0", 64'(log_q[0].adr), 64'h102);

        ack_delay = 1;
        do_cmd("word_rd_mis", 1'b1, 32'h1101, 32'h0, 4'h0, 2'd2, 2, lat);

        ack_never = 1'b1;
        do_cmd("timeout", 1'b1, 32'h50, 32'h0, 4'h0, 2'd0, 0, lat);
        chk("timeout_cyc_cycles", 64'(n_cyc), 64'(255));
        chk("timeout_err", 64'(obs_err), 64'(1));
        chk("timeout_rdata", 64'(obs_rdata), 64'(0));
        ack_never = 1'b0;

        do_cmd("size3", 1'b1, 32'h100, 32'h0, 4'hF, 2'd3, 5, lat);
        chk("size3_err", 64'(obs_err), 64'(1));
        chk("size3_cyc_cycles", 64'(n_cyc), 64'(0));

        spurious = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("spur_rsp_valid", 64'(i_icb_rsp_valid), 64'(0));
            chk("spur_cyc", 64'(wb_cyc), 64'(0));
            chk("spur_cmd_ready", 64'(i_icb_cmd_ready), 64'(1));
        end
        spurious = 1'b0;
        @(posedge clk);

        // Reset during the second beat of a word read
        ack_delay = 3;
        model(1'b1, 32'h100, 32'h0, 4'h0, 2'd2);
        n_acked = 0;
        log_q.delete();
        send_cmd(1'b1, 32'h100, 32'h0, 4'h0, 2'd2, ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (n_acked == 1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("rstmid_beat1_done", 64'(ok), 64'(1));
        @(negedge clk);
        chk("rstmid_beat2_adr", 64'(wb_adr), 64'h101);
        chk("rstmid_beat2_cyc", 64'(wb_cyc), 64'(1));
        rst = 1'b1;
        #1;
        chk("rstmid_cyc_drop", 64'(wb_cyc), 64'(0));
        chk("rstmid_stb_drop", 64'(wb_stb), 64'(0));
        chk("rstmid_no_rsp", 64'(i_icb_rsp_valid), 64'(0));
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstmid_after_valid", 64'(i_icb_rsp_valid), 64'(0));
            chk("rstmid_after_cyc", 64'(wb_cyc), 64'(0));
        end
        chk("rstmid_ready", 64'(i_icb_cmd_ready), 64'(1));

        ack_delay = 1;
        do_cmd("post_rst_rd", 1'b1, 32'h100, 32'h0, 4'h0, 2'd2, 0, lat);
        chk("post_rst_lit", 64'(obs_rdata), 64'h44332211);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
